// File: rtl/ex_stage_pkg.sv
// Shared definitions for the execute stage: op codes,
// common constants, divider FSM encodings and the result bundle.
package ex_stage_pkg;

  localparam logic        RstEnable = 1'b1;
  localparam logic        Valid     = 1'b1;
  localparam logic        Invalid   = 1'b0;
  localparam logic [31:0] Zero      = 32'h0;

  localparam logic [5:0] Nop   = 6'd0;
  localparam logic [5:0] Or    = 6'd1;
  localparam logic [5:0] And   = 6'd2;
  localparam logic [5:0] Xor   = 6'd3;
  localparam logic [5:0] Add   = 6'd4;
  localparam logic [5:0] Sub   = 6'd5;
  localparam logic [5:0] Subr  = 6'd6;
  localparam logic [5:0] Sll   = 6'd7;
  localparam logic [5:0] Srl   = 6'd8;
  localparam logic [5:0] Sra   = 6'd9;
  localparam logic [5:0] Mult  = 6'd10;
  localparam logic [5:0] Multu = 6'd11;
  localparam logic [5:0] Div   = 6'd12;
  localparam logic [5:0] Divu  = 6'd13;
  localparam logic [5:0] Lw    = 6'd14;
  localparam logic [5:0] Sw    = 6'd15;
  localparam logic [5:0] J     = 6'd16;
  localparam logic [5:0] Jal   = 6'd17;
  localparam logic [5:0] Beq   = 6'd18;
  localparam logic [5:0] Bne   = 6'd19;
  localparam logic [5:0] Bltz  = 6'd20;
  localparam logic [5:0] Bgtz  = 6'd21;
  localparam logic [5:0] Lui   = 6'd22;
  localparam logic [5:0] Ll    = 6'd23;
  localparam logic [5:0] Sc    = 6'd24;

  localparam logic [1:0] DivIdle = 2'd0;
  localparam logic [1:0] DivBusy = 2'd1;
  localparam logic [1:0] DivDone = 2'd2;

  typedef struct packed {
    logic [5:0]  op;
    logic [31:0] data;
    logic        write;
    logic [4:0]  addr;
    logic [31:0] mem_addr;
    logic [31:0] mem_data;
  } ex_out_t;

  localparam ex_out_t Bubble = '{
    op: Nop, data: Zero, write: Invalid,
    addr: 5'd0, mem_addr: Zero, mem_data: Zero
  };

  function automatic logic [31:0] mag32(
    input logic        neg,
    input logic [31:0] v
  );
    return neg ? -v : v;
  endfunction

endpackage

// File: rtl/div_unit.sv
// Iterative restoring divider, one quotient bit per cycle,
// operating on magnitudes with a sign fix-up on the way out.
module div_unit
  import ex_stage_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        signed_div,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] quotient,
  output logic [31:0] remainder
);

  logic [1:0]  state;
  logic [4:0]  count;
  logic [31:0] dvs;
  logic [31:0] quo;
  logic [32:0] rem;
  logic        neg_q;
  logic        neg_r;

  logic        sa;
  logic        sb;
  logic [32:0] r_shift;
  logic        take;

  assign sa = signed_div & a[31];
  assign sb = signed_div & b[31];

  // Dividend bits are shifted out of quo as quotient bits shift in.
  assign r_shift = {rem[31:0], quo[31]};
  assign take    = r_shift >= {1'b0, dvs};

  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      state <= DivIdle;
      count <= 5'd0;
      dvs   <= Zero;
      quo   <= Zero;
      rem   <= 33'd0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
    end else begin
      unique case (state)
        DivIdle: begin
          if (start) begin
            dvs   <= mag32(sb, b);
            quo   <= mag32(sa, a);
            rem   <= 33'd0;
            neg_q <= sa ^ sb;
            neg_r <= sa;
            count <= 5'd0;
            state <= DivBusy;
          end
        end
        DivBusy: begin
          rem   <= take ? r_shift - {1'b0, dvs}
                        : r_shift;
          quo   <= {quo[30:0], take};
          count <= count + 5'd1;
          if (count == 5'd31)
            state <= DivDone;
        end
        DivDone: state <= DivIdle;
        default: state <= DivIdle;
      endcase
    end
  end

  assign busy      = state == DivBusy;
  assign done      = state == DivDone;
  assign quotient  = mag32(neg_q, quo);
  assign remainder = mag32(neg_r, rem[31:0]);

endmodule

// File: rtl/ex_stage.sv
// Execute stage: ALU, HI/LO with single-cycle multiply and an
// iterative divider that stalls upstream while it runs.
module ex_stage
  import ex_stage_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  op_i,
  input  logic [31:0] regaData_i,
  input  logic [31:0] regbData_i,
  input  logic        regcWrite_i,
  input  logic [4:0]  regcAddr_i,
  output logic [5:0]  op_o,
  output logic [31:0] regcData_o,
  output logic        regcWrite_o,
  output logic [4:0]  regcAddr_o,
  output logic [31:0] memAddr_o,
  output logic [31:0] memData_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o,
  output logic        stall_o
);

  logic        is_div;
  logic        div_start;
  logic        div_busy;
  logic        div_done;
  logic [31:0] div_q;
  logic [31:0] div_r;
  logic [63:0] prod_s;
  logic [63:0] prod_u;
  logic        wb_ok;
  ex_out_t     nxt;
  ex_out_t     out_q;

  assign is_div    = (op_i == Div) || (op_i == Divu);
  assign div_start = is_div & ~div_busy & ~div_done
                   & (rst != RstEnable);
  assign stall_o   = (rst != RstEnable)
                   & (div_start | div_busy);

  div_unit u_div (
    .clk        (clk),
    .rst        (rst),
    .start      (div_start),
    .signed_div (op_i == Div),
    .a          (regaData_i),
    .b          (regbData_i),
    .busy       (div_busy),
    .done       (div_done),
    .quotient   (div_q),
    .remainder  (div_r)
  );

  assign prod_s = $signed({{32{regaData_i[31]}}, regaData_i})
                * $signed({{32{regbData_i[31]}}, regbData_i});
  assign prod_u = {32'd0, regaData_i} * {32'd0, regbData_i};

  always_comb begin
    nxt      = Bubble;
    wb_ok    = 1'b0;
    nxt.op   = op_i;
    nxt.addr = regcAddr_i;
    unique case (op_i)
      Or:   begin nxt.data = regaData_i | regbData_i; wb_ok = 1'b1; end
      And:  begin nxt.data = regaData_i & regbData_i; wb_ok = 1'b1; end
      Xor:  begin nxt.data = regaData_i ^ regbData_i; wb_ok = 1'b1; end
      Add:  begin nxt.data = regaData_i + regbData_i; wb_ok = 1'b1; end
      Sub,
      Subr: begin nxt.data = regaData_i - regbData_i; wb_ok = 1'b1; end
      Sll: begin
        nxt.data = regbData_i << regaData_i[4:0];
        wb_ok    = 1'b1;
      end
      Srl: begin
        nxt.data = regbData_i >> regaData_i[4:0];
        wb_ok    = 1'b1;
      end
      Sra: begin
        nxt.data = $signed(regbData_i) >>> regaData_i[4:0];
        wb_ok    = 1'b1;
      end
      Lui, J, Jal: begin
        nxt.data = regbData_i;
        wb_ok    = 1'b1;
      end
      Lw: begin
        nxt.mem_addr = regaData_i;
        wb_ok        = 1'b1;
      end
      Sw: begin
        nxt.mem_addr = regaData_i;
        nxt.mem_data = regbData_i;
      end
      Mult, Multu, Div, Divu,
      Beq, Bne, Bltz, Bgtz: wb_ok = 1'b0;
      default: nxt.op = Nop;
    endcase
    nxt.write = regcWrite_i & wb_ok & (regcAddr_i != 5'd0);
  end

  always_ff @(posedge clk) begin
    if (rst == RstEnable)
      out_q <= Bubble;
    else if (stall_o)
      out_q <= Bubble;
    else
      out_q <= nxt;
  end

  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      hi_o <= Zero;
      lo_o <= Zero;
    end else if (div_done) begin
      hi_o <= div_r;
      lo_o <= div_q;
    end else if (!stall_o && op_i == Mult) begin
      hi_o <= prod_s[63:32];
      lo_o <= prod_s[31:0];
    end else if (!stall_o && op_i == Multu) begin
      hi_o <= prod_u[63:32];
      lo_o <= prod_u[31:0];
    end
  end

  assign op_o        = out_q.op;
  assign regcData_o  = out_q.data;
  assign regcWrite_o = out_q.write;
  assign regcAddr_o  = out_q.addr;
  assign memAddr_o   = out_q.mem_addr;
  assign memData_o   = out_q.mem_data;

endmodule

// File: doc/ex_stage.md
EX_STAGE -- requirements
Module: ex_stage

Interface
REQ-001 SHALL have port clk, input, 1, rising-edge clock.
REQ-002 SHALL have port rst, input, 1, reset: synchronous, active-high.
REQ-003 SHALL have ports op_i (input, 6, decoded op code), regaData_i (input, 32, operand A), regbData_i (input, 32, operand B).
REQ-004 SHALL have ports regcWrite_i (input, 1, writeback request) and regcAddr_i (input, 5, destination register).
REQ-005 SHALL have ports op_o (output, 6), regcData_o (output, 32), regcWrite_o (output, 1) and regcAddr_o (output, 5), all registered.
REQ-006 SHALL have ports memAddr_o (output, 32, load/store address) and memData_o (output, 32, store data), both registered.
REQ-007 SHALL have ports hi_o and lo_o (output, 32 each, HI/LO registers) and stall_o (output, 1, combinational: hold upstream).

Function
REQ-008 SHALL register all results at the clock edge: one-cycle latency from inputs to outputs when stall_o=0.
REQ-009 Or, And and Xor SHALL compute A|B, A&B and A^B; Add SHALL compute A+B; Sub and Subr SHALL compute A-B, 32-bit wrap, no overflow trap.
REQ-010 Sll, Srl and Sra SHALL shift B by A[4:0]: logical left, logical right and arithmetic right respectively.
REQ-011 Lui, J and Jal SHALL return B as the result; J therefore has regcWrite_i=0 and Jal carries the link address.
REQ-012 For Lw and Sw, memAddr_o SHALL be A (address is pre-added upstream). For Sw, memData_o SHALL be B. For all other ops, memAddr_o and memData_o SHALL be 0.
REQ-013 Beq, Bne, Bltz and Bgtz SHALL produce result 0 with no writeback.
REQ-014 Ll, Sc, Nop and undefined ops SHALL be forwarded as op_o=Nop with regcWrite_o=0.
REQ-015 regcWrite_o SHALL be forced to 0 when regcAddr_i=0.
REQ-016 Mult SHALL write the signed 64-bit product A*B into {HI,LO} at the edge; Multu SHALL do the same with the unsigned product. Neither op stalls, and both have regcWrite_o=0.
REQ-017 Div and Divu SHALL use an iterative restoring divider with FSM states IDLE, BUSY and DONE, and a 5-bit counter.
REQ-018 In the accept cycle (IDLE with op_i=Div/Divu), the block SHALL assert stall_o=1, latch operand magnitudes and sign flags, and move to BUSY with count=0.
REQ-019 BUSY SHALL produce one quotient bit per cycle; after 32 BUSY cycles the FSM SHALL move to DONE.
REQ-020 The DONE cycle SHALL assert stall_o=0, write HI=remainder and LO=quotient at the edge, and return to IDLE; the held Div op SHALL NOT restart.
REQ-021 stall_o SHALL be 1 for exactly 33 cycles per divide (accept cycle plus 32 BUSY cycles).
REQ-022 While stall_o=1, the output register SHALL load a bubble (op_o=Nop, regcWrite_o=0), and the upstream stage SHALL hold its inputs.
REQ-023 For signed Div, the quotient sign SHALL be signA^signB and the remainder sign SHALL be signA. 0x80000000/-1 SHALL give LO=0x80000000 and HI=0.
REQ-024 Division by zero SHALL still take 33 stall cycles and give LO=0xFFFFFFFF and HI=dividend (Divu); for signed Div, sign fix-up SHALL be applied to these magnitudes.

Reset
REQ-025 When rst=1 at an edge, all registered outputs, HI and LO SHALL be 0, op_o SHALL be Nop, and the FSM SHALL be IDLE.
REQ-026 Reset during BUSY SHALL abort the divide with no HI/LO update, and stall_o SHALL be 0 in the following cycle.
REQ-027 stall_o SHALL be 0 while rst=1.

Structure
REQ-028 Op codes (Or, And, Xor, Add, Sub, Subr, Sll, Srl, Sra, Mult, Multu, Div, Divu, Lw, Sw, J, Jal, Beq, Bne, Bltz, Bgtz, Lui, Ll, Sc, Nop), Zero, Valid, Invalid and RstEnable SHALL come from the shared define header.
REQ-029 The divider FSM state encodings SHALL be added to the shared define header.
REQ-030 The divider SHALL be a sub-module named div_unit with handshake start, signed_div, a, b -> busy, done, quotient, remainder; the ALU and HI/LO SHALL stay in ex_stage.

Verification
REQ-031 Test: Add A=0x7FFFFFFF, B=1, addr 3 -> next cycle regcData_o=0x80000000, regcWrite_o=1, regcAddr_o=3.
REQ-032 Test: Sra A=4, B=0xF0000000 -> regcData_o=0xFF000000. Test: Sll A=31, B=1 -> regcData_o=0x80000000.
REQ-033 Test: Mult A=-2, B=3 -> HI=0xFFFFFFFF, LO=0xFFFFFFFA, and stall_o stays 0.
REQ-034 Test: Div A=-7, B=2 -> stall_o high 33 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF, and regcWrite_o=0 throughout.
REQ-035 Test: Divu A=5, B=0 -> LO=0xFFFFFFFF, HI=5. Test: Div 0x80000000 by -1 -> LO=0x80000000, HI=0.
REQ-036 Test: rst asserted at BUSY cycle 10 -> HI/LO remain 0, FSM is IDLE, and a new Divu 100/7 then yields LO=14, HI=2.
